path_list_reader: RTL

PATH_LIST_READER -- requirements
Module: path_list_reader

---
 rtl/maze_pkg.sv | 19 +
 rtl/path_list_reader_if.sv | 12 +
 rtl/path_list_ram.sv | 36 +++
 rtl/path_list_reader.sv | 138 +++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze types: coordinate width, path-list reader FSM states and the
// packed {x,y} coordinate used when storing or comparing path entries.
package maze_pkg;

    localparam int CW = 4;

    typedef enum logic [1:0] {
        LOAD,
        FETCH,
        STREAM,
        COMPLETE
    } state_t;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } coord_t;

endpackage

// File: rtl/path_list_reader_if.sv
// Valid/ready stream carrying path coordinates out of the path list reader.
interface path_list_reader_if #(
    parameter int CW = maze_pkg::CW
);
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;

    modport master (output out_valid, output out_x, output out_y, input out_ready);
    modport slave  (input out_valid, input out_x, input out_y, output out_ready);
endinterface

// File: rtl/path_list_ram.sv
// Path entry storage: one write port, one synchronous read port with a
// resettable output register so the streamed coordinate is 0 after reset.
module path_list_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rd_data;

    // NOTE: the array is deliberately left out of reset so it maps onto block
    // RAM; readers only ever address entries written since the last clear.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // NOTE: sequential state is always updated with <= so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_rd_data <= '0;
        else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/path_list_reader.sv
// Stores solved maze path entries and streams them back in reverse push order.
// Optional macro PATH_LIST_OVERFLOW_EN enables the sticky overflow flag.
module path_list_reader #(
    parameter int CW    = maze_pkg::CW,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_list,
    input  logic                     list_push,
    input  logic [CW-1:0]            push_x,
    input  logic [CW-1:0]            push_y,
    input  logic                     en_read,
    path_list_reader_if.master       stream,
    output logic                     complete_read,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    import maze_pkg::*;

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH) + 1;

    state_t          r_state;
    logic [CNTW-1:0] r_count;
    logic [AW-1:0]   r_ptr;
    logic            r_out_valid;
    logic            r_complete;

    logic            w_full;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [CNTW-1:0] w_count_m1;
    logic [2*CW-1:0] w_rd_data;

    assign w_full     = (r_count == CNTW'(DEPTH));
    assign w_wr_en    = (r_state == LOAD) && list_push && !init_list && !w_full;
    assign w_rd_en    = (r_state == FETCH);
    assign w_count_m1 = r_count - CNTW'(1);

    path_list_ram #(
        .W     (2*CW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_count[AW-1:0]),
        .i_wr_data ({push_x, push_y}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_ptr),
        .o_rd_data (w_rd_data)
    );

    // The RAM output register holds still outside FETCH, so the streamed
    // coordinate is stable for as long as the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOAD;
            r_count     <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_complete  <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            if (init_list) begin
                r_state     <= LOAD;
                r_count     <= '0;
                r_ptr       <= '0;
                r_out_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    LOAD: begin
                        if (w_wr_en) r_count <= r_count + CNTW'(1);
                        if (en_read) begin
                            if (r_count == '0) begin
                                r_state    <= COMPLETE;
                                r_complete <= 1'b1;
                            end else begin
                                r_ptr   <= w_count_m1[AW-1:0];
                                r_state <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        if (!en_read) begin
                            r_state <= LOAD;
                        end else begin
                            r_state     <= STREAM;
                            r_out_valid <= 1'b1;
                        end
                    end
                    STREAM: begin
                        if (!en_read) begin
                            r_state     <= LOAD;
                            r_out_valid <= 1'b0;
                        end else if (stream.out_ready) begin
                            r_out_valid <= 1'b0;
                            if (r_ptr != '0) begin
                                r_ptr   <= r_ptr - AW'(1);
                                r_state <= FETCH;
                            end else begin
                                r_state    <= COMPLETE;
                                r_complete <= 1'b1;
                            end
                        end
                    end
                    COMPLETE: begin
                        if (!en_read) r_state <= LOAD;
                    end
                    default: r_state <= LOAD;
                endcase
            end
        end
    end

`ifdef PATH_LIST_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          r_overflow <= 1'b0;
        else if (init_list)                               r_overflow <= 1'b0;
        else if ((r_state == LOAD) && list_push && w_full) r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign stream.out_valid = r_out_valid;
    assign stream.out_x     = w_rd_data[2*CW-1:CW];
    assign stream.out_y     = w_rd_data[CW-1:0];
    assign complete_read    = r_complete;
    assign count            = r_count;

endmodule
